// File: rtl/dwt97_column_sequencer.sv
// Column-direction command sequencer for a 9/7 DWT processing unit: walks one frame in
// row pairs with whole-sample symmetric extension at the top and bottom edges.
module dwt97_column_sequencer #(
    parameter int MaximumSideSize = 512,
    parameter int IdxWidth        = $clog2(MaximumSideSize),
    parameter int DimWidth        = IdxWidth + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [DimWidth-1:0] cfg_width_i,
    input  logic [DimWidth-1:0] cfg_height_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                cfg_err_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                m_sof_o,
    output logic                m_eol_o,
    output logic [IdxWidth-1:0] m_even_row_o,
    output logic [IdxWidth-1:0] m_odd_row_o,
    output logic [IdxWidth-1:0] m_col_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRO,
        ST_BODY,
        ST_EPI
    } state_t;

    state_t                state_reg, state_next;
    logic [IdxWidth-1:0]   col_reg, col_next;
    logic [IdxWidth-2:0]   pair_reg, pair_next;
    logic [DimWidth-1:0]   w_reg, w_next;
    logic [DimWidth-1:0]   h_reg, h_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  cfg_err_reg, cfg_err_next;

    logic cfg_legal;
    logic handshake;
    logic last_col;
    logic last_pair;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            col_reg     <= '0;
            pair_reg    <= '0;
            w_reg       <= '0;
            h_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            pair_reg    <= pair_next;
            w_reg       <= w_next;
            h_reg       <= h_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

    always_comb begin
        cfg_legal = (cfg_height_i >= DimWidth'(4))
                 && (cfg_height_i <= DimWidth'(MaximumSideSize))
                 && !cfg_height_i[0]
                 && (cfg_width_i != '0)
                 && (cfg_width_i <= DimWidth'(MaximumSideSize));
        handshake = m_valid_o && m_ready_i;
        last_col  = ({1'b0, col_reg} == (w_reg - DimWidth'(1)));
        last_pair = (DimWidth'(pair_reg) == ((h_reg >> 1) - DimWidth'(1)));
    end

    always_comb begin
        state_next   = state_reg;
        col_next     = col_reg;
        pair_next    = pair_reg;
        w_next       = w_reg;
        h_next       = h_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        cfg_err_next = 1'b0;

        if (state_reg == ST_IDLE) begin
            if (start_i) begin
                if (cfg_legal) begin
                    state_next = ST_PRO;
                    w_next     = cfg_width_i;
                    h_next     = cfg_height_i;
                    col_next   = '0;
                    pair_next  = '0;
                    busy_next  = 1'b1;
                end else begin
                    cfg_err_next = 1'b1;
                end
            end
        end else if (handshake) begin
            if (last_col) begin
                // Row pair finished: state changes land on the same edge, so the
                // next beat is presented without a bubble.
                col_next = '0;
                case (state_reg)
                    ST_PRO: begin
                        state_next = ST_BODY;
                        pair_next  = '0;
                    end
                    ST_BODY: begin
                        if (last_pair) state_next = ST_EPI;
                        else           pair_next  = pair_reg + 1'b1;
                    end
                    default: begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                endcase
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // Beat fields are pure functions of registered state, so they cannot move while stalled.
    always_comb begin
        m_valid_o    = (state_reg != ST_IDLE);
        m_sof_o      = 1'b0;
        m_eol_o      = 1'b0;
        m_even_row_o = '0;
        m_odd_row_o  = '0;
        m_col_o      = '0;
        if (m_valid_o) begin
            m_col_o = col_reg;
            m_eol_o = last_col;
            case (state_reg)
                ST_PRO: begin
                    m_sof_o      = (col_reg == '0);
                    m_even_row_o = IdxWidth'(2);
                    m_odd_row_o  = IdxWidth'(1);
                end
                ST_BODY: begin
                    m_even_row_o = {pair_reg, 1'b0};
                    m_odd_row_o  = {pair_reg, 1'b1};
                end
                default: begin
                    m_even_row_o = IdxWidth'(h_reg - DimWidth'(2));
                    m_odd_row_o  = IdxWidth'(h_reg - DimWidth'(3));
                end
            endcase
        end
    end

    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign cfg_err_o = cfg_err_reg;

endmodule

// File: tb/tb_dwt97_column_sequencer.sv
// Directed bench for dwt97_column_sequencer: frame sequences, backpressure, illegal
// configs, ignored mid-frame start and asynchronous abort.
module tb_dwt97_column_sequencer;

    localparam int IW = 9;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_w = '0;
    logic [DW-1:0] cfg_h = '0;
    logic          m_ready = 1'b0;
    logic          busy, done, cfg_err, m_valid, m_sof, m_eol;
    logic [IW-1:0] m_even, m_odd, m_col;

    int checks = 0;
    int errors = 0;

    dwt97_column_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .cfg_width_i  (cfg_w),
        .cfg_height_i (cfg_h),
        .busy_o       (busy),
        .done_o       (done),
        .cfg_err_o    (cfg_err),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_sof_o      (m_sof),
        .m_eol_o      (m_eol),
        .m_even_row_o (m_even),
        .m_odd_row_o  (m_odd),
        .m_col_o      (m_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] obs_beat();
        return {3'b000, m_sof, m_eol, m_even, m_odd, m_col};
    endfunction

    // Reference beat k of a WxH frame: row pair r = k/W, column k%W.
    function automatic logic [31:0] exp_beat(input int k, input int w, input int h);
        int r, c, ev, od;
        r = k / w;
        c = k % w;
        if (r == 0) begin
            ev = 2; od = 1;
        end else if (r <= h / 2) begin
            ev = 2 * (r - 1); od = ev + 1;
        end else begin
            ev = h - 2; od = h - 3;
        end
        return {3'b000, (k == 0), (c == w - 1), ev[IW-1:0], od[IW-1:0], c[IW-1:0]};
    endfunction

    // Caller is at a negedge; returns at the negedge where done is seen.
    task automatic run_frame(input int w, input int h, input bit rnd_ready,
                             input int mid_start_c, input string tag);
        int k, c, done_c, total;
        logic stalled;
        logic [31:0] prev;
        k = 0; done_c = -1; stalled = 1'b0; prev = '0;
        total = (h / 2 + 2) * w;
        start = 1'b1; cfg_w = DW'(w); cfg_h = DW'(h); m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; c = 1;
        chk({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
        while (c < 20000) begin
            if (c == mid_start_c) begin
                start = 1'b1; cfg_w = DW'(3); cfg_h = DW'(3);
            end else begin
                start = 1'b0;
            end
            if (c == mid_start_c + 1)
                chk({tag, " no_err_mid_start"}, {31'b0, cfg_err}, 32'd0);
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk({tag, " valid_held"}, {31'b0, m_valid}, 32'd1);
                chk({tag, " fields_held"}, obs_beat(), prev);
            end
            if (done) begin
                done_c = c;
                break;
            end
            if (m_valid && m_ready) begin
                chk($sformatf("%s beat%0d", tag, k), obs_beat(), exp_beat(k, w, h));
                k++;
            end
            stalled = m_valid && !m_ready;
            prev = obs_beat();
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk({tag, " beat_count"}, k, total);
        chk({tag, " done_seen"}, {31'b0, (done_c > 0)}, 32'd1);
        // With continuous ready, done follows the last handshake edge by one cycle.
        if (!rnd_ready) chk({tag, " done_cycle"}, done_c, total + 1);
        chk({tag, " busy_low_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic illegal_cfg(input int w, input int h, input string tag);
        start = 1'b1; cfg_w = DW'(w); cfg_h = DW'(h); m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " cfg_err_pulse"}, {31'b0, cfg_err}, 32'd1);
        chk({tag, " busy_low"}, {31'b0, busy}, 32'd0);
        chk({tag, " no_valid"}, {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        chk({tag, " cfg_err_cleared"}, {31'b0, cfg_err}, 32'd0);
        chk({tag, " still_no_valid"}, {31'b0, m_valid}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst valid", {31'b0, m_valid}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst cfg_err", {31'b0, cfg_err}, 32'd0);
        chk("rst fields", obs_beat(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(16, 16, 1'b0, -1, "f16x16");
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);

        // Chained frames: each new start is driven on the previous done cycle.
        run_frame(3, 4, 1'b0, -1, "f3x4");
        run_frame(1, 4, 1'b0, -1, "f1x4");
        run_frame(8, 8, 1'b1, -1, "bp8x8");
        @(negedge clk);

        illegal_cfg(8, 3, "h3");
        illegal_cfg(8, 2, "h2");
        illegal_cfg(8, 0, "h0");
        illegal_cfg(0, 8, "w0");
        illegal_cfg(513, 8, "w513");

        run_frame(4, 8, 1'b0, 10, "mid_start");
        @(negedge clk);

        // Abort a 16x16 frame while beat 20 is on the bus.
        start = 1'b1; cfg_w = DW'(16); cfg_h = DW'(16); m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort beat20", obs_beat(), exp_beat(20, 16, 16));
        rst_n = 1'b0;
        #1;
        chk("abort valid", {31'b0, m_valid}, 32'd0);
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort fields", obs_beat(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no_done", {31'b0, done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort no_done", {31'b0, done}, 32'd0);
        chk("post_abort idle", {31'b0, m_valid}, 32'd0);
        run_frame(16, 16, 1'b0, -1, "after_abort");
        @(negedge clk);

        run_frame(2, 512, 1'b0, -1, "f2x512");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
